pulse_decoder_3to8: RTL and testbench
=====================================

// Module: pulse_decoder_3to8
// PURPOSE
//  Registered 3-to-8 one-hot decoder, the receive-side counterpart of the 8-to-3 encoder.
//  Accepts binary codes over a valid/ready handshake and buffers them in a 2-entry FIFO.
//  Drives the matching one-hot line for HOLD_CYCLES clocks, then idles low for GAP_CYCLES clocks.
//  Sits between a code producer (the encoder path or control logic) and one-hot select/strobe consumers.
// PARAMETERS
//  SEL_W        3   code width; OUT_W = 2**SEL_W (localparam, 8 by default)
//  HOLD_CYCLES  4   clocks each one-hot output stays asserted; legal range >= 1
//  GAP_CYCLES   1   forced all-zero clocks between consecutive pulses; legal range >= 0
// PORTS
//  clk        in   1      single clock; all state on rising edge
//  rst        in   1      asynchronous, active-high reset
//  en         in   1      enable; low = no accept, no pop, current pulse aborted
//  in_code    in   SEL_W  binary code to decode
//  in_valid   in   1      in_code valid this cycle
//  in_ready   out  1      combinational: en && !fifo_full
//  out        out  OUT_W  registered one-hot output; all-zero when not driving
//  out_valid  out  1      registered; high exactly while out is non-zero
//  busy       out  1      combinational: state != IDLE || fifo not empty
// BEHAVIOUR
//  Reset (async, rst=1): out=0, out_valid=0, FIFO empty, state=IDLE, counters=0. Reset takes effect immediately and holds while rst=1.
//  Accept: in_valid && in_ready at edge k writes in_code to the FIFO.
//   in_ready uses the registered count only, with no bypass.
//   A push on a full FIFO cannot occur.
//  FIFO: 2 entries, in order. Push and pop in the same edge are allowed when not full; the count is unchanged.
//  FSM states: IDLE, DRIVE, GAP.
//   IDLE: out=0. If en && !empty: pop at that edge, out <= 1<<code, cnt <= HOLD_CYCLES-1, go DRIVE.
//   DRIVE: out held. If cnt!=0: cnt--. If cnt==0:
//     if GAP_CYCLES==0 && en && !empty: pop and load the next code (back-to-back, no zero cycle)
//     elif GAP_CYCLES==0: out <= 0, go IDLE
//     else: out <= 0, gcnt <= GAP_CYCLES-1, go GAP
//   GAP: out=0. If gcnt!=0: gcnt--. Else go IDLE; the pop happens from IDLE on a later edge.
//  Latency: a code accepted into an empty FIFO at edge k, in IDLE, appears on out after edge k+1.
//  Pulse width is exactly HOLD_CYCLES clocks. The zero gap between pulses is GAP_CYCLES+1 clocks when GAP_CYCLES>0.
//  en low in any state: at the next edge out <= 0, state <= IDLE, counters cleared.
//   FIFO contents are retained and no pops occur.
//   When en rises again, decoding resumes from IDLE with the oldest entry.
//  out_valid == |out at all times; out never has more than one bit set.
//  Every SEL_W code is legal; no default/X output is ever driven.
// TESTING
//  1 Reset mid-pulse: rst=1 while DRIVE with out=8'h20 -> out=0, out_valid=0 with no clock edge; busy=0 after release.
//  2 Single code, defaults: push 3'd5 at edge k -> out=8'b0010_0000 for edges k+1..k+4, then 0; out_valid tracks out.
//  3 Back-to-back, defaults: push 3'd0, 3'd7, 3'd3 with in_valid held high.
//    -> in_ready drops when the FIFO holds 2 entries.
//    -> out sequence is 01 x4, 00 x2, 80 x4, 00 x2, 08 x4.
//  4 GAP_CYCLES=0, HOLD_CYCLES=1: push 1,2 -> out=02 then 04 on consecutive clocks, no zero cycle between.
//  5 en abort: push 3'd6 and 3'd1; drop en during the 2nd hold cycle of 6.
//    -> out=0 next edge; in_ready=0; FIFO still holds 1.
//    -> after en=1, out=02 for 4 clocks.
//  6 Exhaustive: push all 8 codes in order -> each out equals 1<<code, one bit set, with correct hold/gap timing.

Source files
------------

// File: rtl/pulse_decoder_3to8_if.sv
// rtl/pulse_decoder_3to8_if.sv - code input handshake and one-hot output bundle for pulse_decoder_3to8
interface pulse_decoder_3to8_if #(
    parameter int SEL_W = 3
);
    localparam int OUT_W = 2**SEL_W;

    logic [SEL_W-1:0] in_code;
    logic             in_valid;
    logic             in_ready;
    logic [OUT_W-1:0] out;
    logic             out_valid;

    modport master (
        output in_code,
        output in_valid,
        input  in_ready,
        input  out,
        input  out_valid
    );

    modport slave (
        input  in_code,
        input  in_valid,
        output in_ready,
        output out,
        output out_valid
    );
endinterface

// File: rtl/pulse_decoder_3to8.sv
// rtl/pulse_decoder_3to8.sv - registered 3-to-8 one-hot pulse decoder with a 2-entry input FIFO
module pulse_decoder_3to8 #(
    parameter int SEL_W       = 3,
    parameter int HOLD_CYCLES = 4,
    parameter int GAP_CYCLES  = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    pulse_decoder_3to8_if.slave  bus,
    output logic                 busy
);
    localparam int OUT_W  = 2**SEL_W;
    localparam int CNT_W  = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam int GCNT_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [CNT_W-1:0]  HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [GCNT_W-1:0] GAP_LOAD  = GCNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_GAP} state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [GCNT_W-1:0] gcnt_q, gcnt_d;
    logic [OUT_W-1:0]  out_q, out_d;
    logic              out_valid_q;

    logic [SEL_W-1:0]  mem_q [2];
    logic              rd_ptr_q, wr_ptr_q;
    logic [1:0]        count_q;

    logic              fifo_empty, fifo_full, push, pop;
    logic [OUT_W-1:0]  head_onehot;

    assign fifo_empty   = (count_q == 2'd0);
    assign fifo_full    = (count_q == 2'd2);
    assign bus.in_ready = en && !fifo_full;
    assign push         = bus.in_valid && bus.in_ready;
    assign head_onehot  = OUT_W'(1) << mem_q[rd_ptr_q];
    assign bus.out       = out_q;
    assign bus.out_valid = out_valid_q;
    assign busy          = (state_q != S_IDLE) || !fifo_empty;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        gcnt_d  = gcnt_q;
        out_d   = out_q;
        pop     = 1'b0;
        if (!en) begin
            // Dropping enable aborts the pulse but leaves queued codes in place.
            state_d = S_IDLE;
            cnt_d   = '0;
            gcnt_d  = '0;
            out_d   = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    out_d = '0;
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        out_d   = head_onehot;
                        cnt_d   = HOLD_LOAD;
                        state_d = S_DRIVE;
                    end
                end
                S_DRIVE: begin
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end else if (GAP_CYCLES == 0 && !fifo_empty) begin
                        pop   = 1'b1;
                        out_d = head_onehot;
                        cnt_d = HOLD_LOAD;
                    end else if (GAP_CYCLES == 0) begin
                        out_d   = '0;
                        state_d = S_IDLE;
                    end else begin
                        out_d   = '0;
                        gcnt_d  = GAP_LOAD;
                        state_d = S_GAP;
                    end
                end
                S_GAP: begin
                    out_d = '0;
                    if (gcnt_q != '0) gcnt_d = gcnt_q - GCNT_W'(1);
                    else              state_d = S_IDLE;
                end
                default: begin
                    out_d   = '0;
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            gcnt_q      <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            mem_q[0]    <= '0;
            mem_q[1]    <= '0;
            rd_ptr_q    <= 1'b0;
            wr_ptr_q    <= 1'b0;
            count_q     <= 2'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            gcnt_q      <= gcnt_d;
            out_q       <= out_d;
            out_valid_q <= |out_d;
            if (push) begin
                mem_q[wr_ptr_q] <= bus.in_code;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop) rd_ptr_q <= ~rd_ptr_q;
            count_q <= count_q + {1'b0, push} - {1'b0, pop};
        end
    end
endmodule

// File: tb/tb_pulse_decoder_3to8.sv
// tb/tb_pulse_decoder_3to8.sv - testbench for pulse_decoder_3to8
module tb_pulse_decoder_3to8;
    localparam int HA = 4, GA = 1, HB = 1, GB = 0;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic en  = 1'b1;
    logic busy_a, busy_b;

    always #5 clk = ~clk;

    pulse_decoder_3to8_if #(.SEL_W(3)) ifa ();
    pulse_decoder_3to8_if #(.SEL_W(3)) ifb ();

    pulse_decoder_3to8 #(.SEL_W(3), .HOLD_CYCLES(HA), .GAP_CYCLES(GA)) dut_a (
        .clk(clk), .rst(rst), .en(en), .bus(ifa.slave), .busy(busy_a));
    pulse_decoder_3to8 #(.SEL_W(3), .HOLD_CYCLES(HB), .GAP_CYCLES(GB)) dut_b (
        .clk(clk), .rst(rst), .en(en), .bus(ifb.slave), .busy(busy_b));

    int compared = 0, mismatched = 0;

    // Timestamp model: a pulse started at edge s occupies edges s..s+H-1, and the
    // next pop may happen no earlier than s+H (+GAP+1 when a gap is configured).
    int         cyc;
    int         mq [2][$];
    logic [7:0] m_out [2];
    bit         m_act [2], m_acc [2];
    int         m_start [2], m_earliest [2];
    int         feed_a [$], feed_b [$];

    function automatic bit exp_ready(input int i);
        return en && (mq[i].size() < 2);
    endfunction

    function automatic bit exp_busy(input int i);
        return m_act[i] || (mq[i].size() > 0) || (cyc < m_earliest[i] - 1);
    endfunction

    task automatic model_step(input int i, input int h, input int g, input bit v, input logic [2:0] code);
        int pre;
        pre      = mq[i].size();
        m_acc[i] = en && v && (pre < 2);
        if (!en) begin
            m_out[i]      = 8'h00;
            m_act[i]      = 1'b0;
            m_earliest[i] = cyc + 1;
        end else begin
            if (m_act[i] && cyc == m_start[i] + h) begin
                m_out[i] = 8'h00;
                m_act[i] = 1'b0;
            end
            if (!m_act[i] && cyc >= m_earliest[i] && pre > 0) begin
                m_out[i]      = 8'h01 << mq[i].pop_front();
                m_act[i]      = 1'b1;
                m_start[i]    = cyc;
                m_earliest[i] = cyc + h + ((g > 0) ? g + 1 : 0);
            end
        end
        if (m_acc[i]) mq[i].push_back(int'(code));
    endtask

    initial begin
        cyc = 0;
        for (int i = 0; i < 2; i++) begin
            m_out[i] = 8'h00; m_act[i] = 1'b0; m_acc[i] = 1'b0; m_start[i] = 0; m_earliest[i] = 0;
        end
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                cyc = 0;
                for (int i = 0; i < 2; i++) begin
                    mq[i].delete();
                    m_out[i] = 8'h00; m_act[i] = 1'b0; m_acc[i] = 1'b0; m_start[i] = 0; m_earliest[i] = 0;
                end
            end else begin
                cyc++;
                model_step(0, HA, GA, ifa.in_valid, ifa.in_code);
                model_step(1, HB, GB, ifb.in_valid, ifb.in_code);
            end
        end
    end

    // Producers: present the head of each feed queue and hold it until accepted.
    initial begin
        ifa.in_valid = 1'b0; ifa.in_code = 3'd0;
        ifb.in_valid = 1'b0; ifb.in_code = 3'd0;
        forever begin
            @(negedge clk);
            if (rst) begin
                feed_a.delete(); feed_b.delete();
                ifa.in_valid = 1'b0; ifb.in_valid = 1'b0;
            end else begin
                if (ifa.in_valid && m_acc[0]) void'(feed_a.pop_front());
                if (ifb.in_valid && m_acc[1]) void'(feed_b.pop_front());
                ifa.in_valid = (feed_a.size() > 0);
                if (feed_a.size() > 0) ifa.in_code = 3'(feed_a[0]);
                ifb.in_valid = (feed_b.size() > 0);
                if (feed_b.size() > 0) ifb.in_code = 3'(feed_b[0]);
            end
        end
    end

    task automatic test_reset();
        #1 rst = 1'b1;
        #1;
        compared++;
        if (ifa.out !== 8'h00 || ifa.out_valid !== 1'b0 || busy_a !== 1'b0 || ifa.in_ready !== 1'b1) begin
            mismatched++;
            $display("FAIL reset out=%h ov=%b busy=%b rdy=%b want 00 0 0 1", ifa.out, ifa.out_valid, busy_a, ifa.in_ready);
        end
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset_mid_pulse();
        int waited = 0;
        feed_a.push_back(5);
        while (ifa.out !== 8'h20 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        compared++;
        if (ifa.out !== 8'h20) begin
            mismatched++;
            $display("FAIL mid_pulse_start out=%h want 20", ifa.out);
        end
        rst = 1'b1;
        #1;
        compared++;
        if (ifa.out !== 8'h00 || ifa.out_valid !== 1'b0) begin
            mismatched++;
            $display("FAIL mid_pulse_reset out=%h ov=%b want 00 0", ifa.out, ifa.out_valid);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        compared++;
        if (busy_a !== 1'b0 || ifa.out !== 8'h00) begin
            mismatched++;
            $display("FAIL mid_pulse_release busy=%b out=%h want 0 00", busy_a, ifa.out);
        end
    endtask

    task automatic test_single();
        int hi = 0;
        feed_a.push_back(5);
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            compared++;
            if (ifa.out !== m_out[0] || ifa.out_valid !== (m_out[0] != 8'h0) || ifa.in_ready !== exp_ready(0) || busy_a !== exp_busy(0)) begin
                mismatched++;
                $display("FAIL single cyc=%0d out=%h ov=%b rdy=%b busy=%b want %h %b %b %b", cyc, ifa.out, ifa.out_valid,
                         ifa.in_ready, busy_a, m_out[0], m_out[0] != 8'h0, exp_ready(0), exp_busy(0));
            end
            if (ifa.out === 8'h20) hi++;
        end
        compared++;
        if (hi != HA) begin
            mismatched++;
            $display("FAIL single_width got=%0d want=%0d", hi, HA);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] want [16] = '{8'h01, 8'h01, 8'h01, 8'h01, 8'h00, 8'h00, 8'h80, 8'h80,
                                  8'h80, 8'h80, 8'h00, 8'h00, 8'h08, 8'h08, 8'h08, 8'h08};
        logic [7:0] seq [$];
        bit         saw_full = 1'b0;
        feed_a.push_back(0); feed_a.push_back(7); feed_a.push_back(3);
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            compared++;
            if (ifa.out !== m_out[0] || ifa.out_valid !== (m_out[0] != 8'h0) || ifa.in_ready !== exp_ready(0) || busy_a !== exp_busy(0)) begin
                mismatched++;
                $display("FAIL b2b cyc=%0d out=%h ov=%b rdy=%b busy=%b want %h %b %b %b", cyc, ifa.out, ifa.out_valid,
                         ifa.in_ready, busy_a, m_out[0], m_out[0] != 8'h0, exp_ready(0), exp_busy(0));
            end
            if (ifa.in_ready === 1'b0) saw_full = 1'b1;
            if ((seq.size() > 0 || ifa.out !== 8'h00) && seq.size() < 16) seq.push_back(ifa.out);
        end
        compared++;
        if (!saw_full) begin
            mismatched++;
            $display("FAIL b2b_ready_drop got=never_low want=low_once");
        end
        for (int i = 0; i < 16; i++) begin
            compared++;
            if (i >= seq.size() || seq[i] !== want[i]) begin
                mismatched++;
                $display("FAIL b2b_seq[%0d] got=%h want=%h", i, (i < seq.size()) ? seq[i] : 8'hxx, want[i]);
            end
        end
    endtask

    task automatic test_no_gap();
        logic [7:0] want [3] = '{8'h02, 8'h04, 8'h00};
        logic [7:0] seq [$];
        feed_b.push_back(1); feed_b.push_back(2);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            compared++;
            if (ifb.out !== m_out[1] || ifb.out_valid !== (m_out[1] != 8'h0) || ifb.in_ready !== exp_ready(1) || busy_b !== exp_busy(1)) begin
                mismatched++;
                $display("FAIL nogap cyc=%0d out=%h ov=%b rdy=%b busy=%b want %h %b %b %b", cyc, ifb.out, ifb.out_valid,
                         ifb.in_ready, busy_b, m_out[1], m_out[1] != 8'h0, exp_ready(1), exp_busy(1));
            end
            if ((seq.size() > 0 || ifb.out !== 8'h00) && seq.size() < 3) seq.push_back(ifb.out);
        end
        for (int i = 0; i < 3; i++) begin
            compared++;
            if (i >= seq.size() || seq[i] !== want[i]) begin
                mismatched++;
                $display("FAIL nogap_seq[%0d] got=%h want=%h", i, (i < seq.size()) ? seq[i] : 8'hxx, want[i]);
            end
        end
    endtask

    task automatic test_en_abort();
        int waited = 0;
        int ones = 0;
        feed_a.push_back(6); feed_a.push_back(1);
        while (ifa.out !== 8'h40 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        @(negedge clk);
        compared++;
        if (ifa.out !== 8'h40) begin
            mismatched++;
            $display("FAIL abort_hold2 out=%h want 40", ifa.out);
        end
        en = 1'b0;
        @(negedge clk);
        compared++;
        if (ifa.out !== 8'h00 || ifa.out_valid !== 1'b0 || ifa.in_ready !== 1'b0 || busy_a !== 1'b1) begin
            mismatched++;
            $display("FAIL abort_drop out=%h ov=%b rdy=%b busy=%b want 00 0 0 1", ifa.out, ifa.out_valid, ifa.in_ready, busy_a);
        end
        @(negedge clk);
        en = 1'b1;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            compared++;
            if (ifa.out !== m_out[0] || ifa.out_valid !== (m_out[0] != 8'h0) || ifa.in_ready !== exp_ready(0) || busy_a !== exp_busy(0)) begin
                mismatched++;
                $display("FAIL abort cyc=%0d out=%h ov=%b rdy=%b busy=%b want %h %b %b %b", cyc, ifa.out, ifa.out_valid,
                         ifa.in_ready, busy_a, m_out[0], m_out[0] != 8'h0, exp_ready(0), exp_busy(0));
            end
            if (ifa.out === 8'h02) ones++;
            if (c == 0 && ifa.out !== 8'h02) begin
                mismatched++;
                $display("FAIL abort_resume out=%h want 02", ifa.out);
            end
        end
        compared++;
        if (ones != HA) begin
            mismatched++;
            $display("FAIL abort_resume_width got=%0d want=%0d", ones, HA);
        end
    endtask

    task automatic test_exhaustive();
        logic [7:0] starts [$];
        logic [7:0] prev = 8'h00;
        for (int i = 0; i < 8; i++) feed_a.push_back(i);
        for (int c = 0; c < 70; c++) begin
            @(negedge clk);
            compared++;
            if (ifa.out !== m_out[0] || ifa.out_valid !== (m_out[0] != 8'h0) || ifa.in_ready !== exp_ready(0) || busy_a !== exp_busy(0)
                || $countones(ifa.out) > 1) begin
                mismatched++;
                $display("FAIL exhaust cyc=%0d out=%h ov=%b rdy=%b busy=%b want %h %b %b %b", cyc, ifa.out, ifa.out_valid,
                         ifa.in_ready, busy_a, m_out[0], m_out[0] != 8'h0, exp_ready(0), exp_busy(0));
            end
            if (ifa.out !== 8'h00 && ifa.out !== prev) starts.push_back(ifa.out);
            prev = ifa.out;
        end
        for (int i = 0; i < 8; i++) begin
            compared++;
            if (i >= starts.size() || starts[i] !== (8'h01 << i)) begin
                mismatched++;
                $display("FAIL exhaust_code[%0d] got=%h want=%h", i, (i < starts.size()) ? starts[i] : 8'hxx, 8'h01 << i);
            end
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            compared++;
            if (ifa.out !== m_out[0] || ifa.out_valid !== (m_out[0] != 8'h0) || ifa.in_ready !== exp_ready(0) || busy_a !== exp_busy(0)) begin
                mismatched++;
                $display("FAIL rand_a cyc=%0d out=%h ov=%b rdy=%b busy=%b want %h %b %b %b", cyc, ifa.out, ifa.out_valid,
                         ifa.in_ready, busy_a, m_out[0], m_out[0] != 8'h0, exp_ready(0), exp_busy(0));
            end
            compared++;
            if (ifb.out !== m_out[1] || ifb.out_valid !== (m_out[1] != 8'h0) || ifb.in_ready !== exp_ready(1) || busy_b !== exp_busy(1)) begin
                mismatched++;
                $display("FAIL rand_b cyc=%0d out=%h ov=%b rdy=%b busy=%b want %h %b %b %b", cyc, ifb.out, ifb.out_valid,
                         ifb.in_ready, busy_b, m_out[1], m_out[1] != 8'h0, exp_ready(1), exp_busy(1));
            end
            en = ($urandom_range(0, 9) != 0);
            if (feed_a.size() < 2 && $urandom_range(0, 2) == 0) feed_a.push_back(int'($urandom_range(0, 7)));
            if (feed_b.size() < 2 && $urandom_range(0, 1) == 0) feed_b.push_back(int'($urandom_range(0, 7)));
        end
        en = 1'b1;
    endtask

    initial begin
        test_reset();
        test_reset_mid_pulse();
        test_single();
        test_back_to_back();
        test_no_gap();
        test_en_abort();
        test_exhaustive();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
